// File: rtl/cpu_trace_buffer.sv
// cpu_trace_buffer: retirement-trace capture for the multicycle MIPS CPU.
// Logs one {pc, reg, data} record per register-file write into a show-ahead FIFO.
// The FIFO drains over a valid/ready port. It only observes the CPU and never stalls it.
// Optional feature: define TRACE_TIMESTAMP_EN to add a free-running cycle counter.
// With that macro defined, each record also carries the counter value in trace_time.
module cpu_trace_buffer #(
    parameter int unsigned DEPTH       = 16,
    parameter logic [6:0]  FETCH_STATE = 7'd0,
    parameter int unsigned DROP_W      = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [6:0]               estado,
    input  logic [31:0]              pc_in,
    input  logic                     wb_en,
    input  logic [4:0]               wb_addr,
    input  logic [31:0]              wb_data,
    input  logic                     trace_en,
    input  logic                     clear,
    output logic                     trace_valid,
    input  logic                     trace_ready,
    output logic [31:0]              trace_pc,
    output logic [4:0]               trace_reg,
    output logic [31:0]              trace_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic [DROP_W-1:0]        drop_count
`ifdef TRACE_TIMESTAMP_EN
    ,
    output logic [31:0]              trace_time
`endif
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = 1;
    localparam logic [DROP_W-1:0] DropOne = 1;
    localparam logic [DROP_W-1:0] DropMax = '1;

    logic [AW:0]        wr_ptr_q, rd_ptr_q;
    logic [DROP_W-1:0]  drop_q;
    logic [31:0]        cur_pc_q;
    logic [6:0]         prev_state_q;

    logic [31:0]        mem_pc   [DEPTH];
    logic [4:0]         mem_reg  [DEPTH];
    logic [31:0]        mem_data [DEPTH];

    logic [AW-1:0]      wr_idx, rd_idx;
    logic               full, push_req, pop, push_ok, drop, fetch_edge;

`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]        time_q;
    logic [31:0]        mem_time [DEPTH];
`endif

    // FIFO status and push/pop qualification
    always_comb begin
        wr_idx      = wr_ptr_q[AW-1:0];
        rd_idx      = rd_ptr_q[AW-1:0];
        level       = wr_ptr_q - rd_ptr_q;
        full        = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_idx == rd_idx);
        trace_valid = (level != '0);
        push_req    = trace_en && wb_en && (wb_addr != 5'd0);
        pop         = trace_valid && trace_ready;
        // A same-cycle pop frees the slot that a push into a full FIFO needs
        push_ok     = push_req && (!full || pop);
        drop        = push_req && full && !pop;
        fetch_edge  = (estado == FETCH_STATE) && (prev_state_q != FETCH_STATE);
        drop_count  = drop_q;
    end

    // Head record shown ahead. All fields read zero while the FIFO is empty.
    always_comb begin
        trace_pc   = trace_valid ? mem_pc[rd_idx]   : '0;
        trace_reg  = trace_valid ? mem_reg[rd_idx]  : '0;
        trace_data = trace_valid ? mem_data[rd_idx] : '0;
`ifdef TRACE_TIMESTAMP_EN
        trace_time = trace_valid ? mem_time[rd_idx] : '0;
`endif
    end

    // Pointers and drop counter. Clear flushes the FIFO but leaves PC tracking alone.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else if (clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            drop_q   <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + PtrOne;
            if (pop)     rd_ptr_q <= rd_ptr_q + PtrOne;
            if (drop && drop_q != DropMax) drop_q <= drop_q + DropOne;
        end
    end

    // Latch the instruction PC on fetch entry only. A record logged on the same edge keeps the old PC.
    always_ff @(posedge clock) begin
        if (reset) begin
            cur_pc_q     <= '0;
            prev_state_q <= '0;
        end else begin
            if (fetch_edge) cur_pc_q <= pc_in;
            prev_state_q <= estado;
        end
    end

    // Record storage needs no reset because the pointers gate visibility
    always_ff @(posedge clock) begin
        if (!reset && !clear && push_ok) begin
            mem_pc[wr_idx]   <= cur_pc_q;
            mem_reg[wr_idx]  <= wb_addr;
            mem_data[wr_idx] <= wb_data;
`ifdef TRACE_TIMESTAMP_EN
            mem_time[wr_idx] <= time_q;
`endif
        end
    end

`ifdef TRACE_TIMESTAMP_EN
    // Free-running cycle counter. It wraps naturally and clear does not reset it.
    always_ff @(posedge clock) begin
        if (reset) time_q <= '0;
        else       time_q <= time_q + 32'd1;
    end
`endif

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// tb_cpu_trace_buffer: randomized scoreboard bench for cpu_trace_buffer.
// It models the FIFO as a bounded queue of expected records.
module tb_cpu_trace_buffer;

    localparam int unsigned DEPTH  = 8;
    localparam int unsigned DROP_W = 4;
    localparam logic [6:0]  FETCH  = 7'd0;
    localparam int unsigned LW     = $clog2(DEPTH) + 1;
    localparam int unsigned NCYC   = 4000;

    logic              clock = 1'b0;
    logic              reset, wb_en, trace_en, clear, trace_ready;
    logic [6:0]        estado;
    logic [31:0]       pc_in, wb_data;
    logic [4:0]        wb_addr;
    logic              trace_valid;
    logic [31:0]       trace_pc, trace_data;
    logic [4:0]        trace_reg;
    logic [LW-1:0]     level;
    logic [DROP_W-1:0] drop_count;
`ifdef TRACE_TIMESTAMP_EN
    logic [31:0]       trace_time;
`endif

    cpu_trace_buffer #(
        .DEPTH       (DEPTH),
        .FETCH_STATE (FETCH),
        .DROP_W      (DROP_W)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .estado      (estado),
        .pc_in       (pc_in),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .trace_en    (trace_en),
        .clear       (clear),
        .trace_valid (trace_valid),
        .trace_ready (trace_ready),
        .trace_pc    (trace_pc),
        .trace_reg   (trace_reg),
        .trace_data  (trace_data),
        .level       (level),
        .drop_count  (drop_count)
`ifdef TRACE_TIMESTAMP_EN
        ,
        .trace_time  (trace_time)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] t;
    } rec_t;

    rec_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          started  = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [6:0]  m_prev;
    int          m_drops;
    logic [31:0] m_time;

    task automatic check(input string name, input logic [79:0] got, input logic [79:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Advance the model across the coming clock edge, using the inputs now driven
    task automatic step_model();
        rec_t r;
        bit   pop_m;
        if (reset) begin
            sb.delete();
            m_drops = 0;
            m_pc    = '0;
            m_prev  = '0;
            m_time  = '0;
            return;
        end
        r.pc   = m_pc;
        r.rd   = wb_addr;
        r.data = wb_data;
        r.t    = m_time;
        if (clear) begin
            sb.delete();
            m_drops = 0;
        end else begin
            pop_m = (sb.size() > 0) && trace_ready;
            if (trace_en && wb_en && wb_addr != 5'd0) begin
                if (sb.size() < DEPTH || pop_m) sb.push_back(r);
                else if (m_drops < (2 ** DROP_W) - 1) m_drops++;
            end
        end
        if (estado == FETCH && m_prev != FETCH) m_pc = pc_in;
        m_prev = estado;
        m_time = m_time + 32'd1;
    endtask

    task automatic check_state();
        check("level", 80'(level), 80'(sb.size()));
        check("drop_count", 80'(drop_count), 80'(m_drops));
        check("trace_valid", 80'(trace_valid), 80'(sb.size() > 0));
    endtask

    // Monitor: on accepted handshakes, pop the scoreboard and compare the head record
    initial begin
        rec_t r;
        wait (started);
        forever begin
            @(negedge clock);
            if (!trace_valid) begin
                check("idle_fields", {11'd0, trace_pc, trace_reg, trace_data}, 80'd0);
            end else if (trace_ready && !clear && !reset) begin
                if (sb.size() == 0) begin
                    check("pop_nonempty_model", 80'd1, 80'd0);
                end else begin
                    r = sb.pop_front();
                    check("trace_pc", 80'(trace_pc), 80'(r.pc));
                    check("trace_reg", 80'(trace_reg), 80'(r.rd));
                    check("trace_data", 80'(trace_data), 80'(r.data));
`ifdef TRACE_TIMESTAMP_EN
                    check("trace_time", 80'(trace_time), 80'(r.t));
`endif
                end
            end
        end
    end

    // Driver: randomized phases alternate draining, filling, and mixed traffic
    initial begin
        int          phase;
        int unsigned rdy_pct;
        logic [6:0]  states [5];
        states[0] = FETCH;
        states[1] = 7'd1;
        states[2] = 7'd2;
        states[3] = 7'd5;
        states[4] = 7'd9;

        reset = 1'b1; clear = 1'b0; estado = 7'd5; pc_in = '0; wb_en = 1'b0;
        wb_addr = '0; wb_data = '0; trace_en = 1'b1; trace_ready = 1'b0;
        step_model();
        @(posedge clock); #1;
        step_model();
        @(posedge clock); #1;
        started = 1;
        check_state();
        reset = 1'b0;

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            phase = (cyc / 150) % 4;
            case (phase)
                0: rdy_pct = 90;
                1: rdy_pct = 10;
                2: rdy_pct = 0;
                default: rdy_pct = 50;
            endcase
            trace_ready = ($urandom_range(99) < rdy_pct);
            if ($urandom_range(99) < 30) estado = states[$urandom_range(4)];
            pc_in    = $urandom;
            wb_en    = ($urandom_range(99) < 55);
            wb_addr  = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            wb_data  = $urandom;
            trace_en = ($urandom_range(9) != 0);
            clear    = ($urandom_range(199) == 0);
            reset    = ($urandom_range(799) == 0);
            step_model();
            @(posedge clock); #1;
            check_state();
        end

        // Final drain with capture off
        reset = 1'b0; clear = 1'b0; trace_en = 1'b0; trace_ready = 1'b1;
        for (int i = 0; i < DEPTH + 4; i++) begin
            step_model();
            @(posedge clock); #1;
            check_state();
        end
        check("final_level", 80'(level), 80'd0);

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
